// File: rtl/adc_cfg_pkg.sv
// adc_cfg_pkg: shared states, source codes and constants for the ADC config sequencer
package adc_cfg_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_SELECT, S_SCAN, S_START, S_GUARD, S_WAIT, S_FAIL, S_NEXT, S_FINISH
  } state_t;
  localparam logic [1:0] SRC_PWRUP = 2'd0;
  localparam logic [1:0] SRC_JTAG = 2'd1;
  localparam logic [1:0] SRC_CSP = 2'd2;
  localparam logic [63:0] MASK_ALL = '1;
  localparam int GUARD_LEN = 2;
endpackage

// File: rtl/adc_cfg_req_latch.sv
// adc_cfg_req_latch: one request source's pending flag and captured ADC mask
module adc_cfg_req_latch #(
  parameter int NADC = 12
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            req,
  input  logic [NADC-1:0] mask_in,
  input  logic            clr,
  output logic            pend,
  output logic [NADC-1:0] mask
);
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend <= 1'b0;
      mask <= '0;
    end else begin
      pend <= req | (pend & ~clr);
      if (req) mask <= mask_in;
    end
  end
endmodule

// File: rtl/adc_cfg_sequencer.sv
// adc_cfg_sequencer: arbitrates power-up/JTAG/ChipScope requests and walks each mask through adc_config.
// Define ADC_CFG_RETRY_EN to re-issue INIT up to MAX_RETRY times after a DONE timeout.
module adc_cfg_sequencer
  import adc_cfg_pkg::*;
#(
  parameter int NADC = 12,
  parameter int PWRUP_DLY = 1000,
  parameter int DONE_TMO = 4096,
  parameter int MAX_RETRY = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            PWRUP_EN,
  input  logic            JTAG_REQ,
  input  logic [NADC-1:0] JTAG_MASK,
  input  logic            CSP_REQ,
  input  logic [NADC-1:0] CSP_MASK,
  input  logic            CFG_DONE,
  output logic            CFG_INIT,
  output logic [NADC-1:0] CFG_MASK,
  output logic            BUSY,
  output logic            JOB_DONE,
  output logic [1:0]      JOB_SRC,
  output logic [NADC-1:0] ERR_MASK
);
  localparam int PW = $clog2(PWRUP_DLY + 2);
  localparam logic [15:0] GUARD_END = 16'(GUARD_LEN - 1);
  localparam logic [15:0] TMO_END = 16'(DONE_TMO + GUARD_LEN - 1);
  state_t state;
  logic [PW-1:0] pcnt;
  logic pw_req;
  logic [2:0] pend, clr;
  logic [NADC-1:0] smask [3];
  logic [1:0] src, sel;
  logic [NADC-1:0] job_mask, rem, low;
  logic [15:0] timer;
`ifdef ADC_CFG_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 2);
  logic [RW-1:0] retry;
`endif
  assign pw_req = PWRUP_EN & (pcnt == PW'(PWRUP_DLY));
  assign sel = pend[0] ? SRC_PWRUP : pend[1] ? SRC_JTAG : SRC_CSP;
  // lowest pending bit is the highest-priority source
  assign clr = (state == S_IDLE) ? pend & (~pend + 3'd1) : 3'd0;
  assign job_mask = (src == SRC_PWRUP) ? smask[0] : (src == SRC_JTAG) ? smask[1] : smask[2];
  assign low = rem & (~rem + NADC'(1));
  adc_cfg_req_latch #(.NADC(NADC)) u_pwr (
    .CLK(CLK), .RST(RST), .req(pw_req), .mask_in(MASK_ALL[NADC-1:0]),
    .clr(clr[0]), .pend(pend[0]), .mask(smask[0])
  );
  adc_cfg_req_latch #(.NADC(NADC)) u_jtag (
    .CLK(CLK), .RST(RST), .req(JTAG_REQ), .mask_in(JTAG_MASK),
    .clr(clr[1]), .pend(pend[1]), .mask(smask[1])
  );
  adc_cfg_req_latch #(.NADC(NADC)) u_csp (
    .CLK(CLK), .RST(RST), .req(CSP_REQ), .mask_in(CSP_MASK),
    .clr(clr[2]), .pend(pend[2]), .mask(smask[2])
  );
  always_ff @(posedge CLK) begin
    if (RST) pcnt <= '0;
    else if (pcnt <= PW'(PWRUP_DLY)) pcnt <= pcnt + PW'(1);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      src <= SRC_PWRUP;
      rem <= '0;
      timer <= '0;
      CFG_INIT <= 1'b0;
      CFG_MASK <= '0;
      BUSY <= 1'b0;
      JOB_DONE <= 1'b0;
      JOB_SRC <= SRC_PWRUP;
      ERR_MASK <= '0;
`ifdef ADC_CFG_RETRY_EN
      retry <= '0;
`endif
    end else begin
      CFG_INIT <= 1'b0;
      JOB_DONE <= 1'b0;
      timer <= (&timer) ? timer : timer + 16'd1;
      case (state)
        S_IDLE: if (|pend) begin
          src <= sel;
          BUSY <= 1'b1;
          state <= S_SELECT;
        end
        S_SELECT: begin
          rem <= job_mask;
          JOB_SRC <= src;
          ERR_MASK <= '0;
          state <= S_SCAN;
        end
        S_SCAN: if (|rem) begin
          CFG_MASK <= low;
          CFG_INIT <= 1'b1;
          state <= S_START;
        end else begin
          JOB_DONE <= 1'b1;
          state <= S_FINISH;
        end
        S_START: begin
          timer <= '0;
          state <= S_GUARD;
        end
        S_GUARD: if (timer == GUARD_END) state <= S_WAIT;
        S_WAIT: if (CFG_DONE) begin
          CFG_MASK <= '0;
          state <= S_NEXT;
        end else if (timer >= TMO_END) begin
`ifdef ADC_CFG_RETRY_EN
          if (retry < RW'(MAX_RETRY)) begin
            retry <= retry + RW'(1);
            CFG_INIT <= 1'b1;
            state <= S_START;
          end else state <= S_FAIL;
`else
          state <= S_FAIL;
`endif
        end
        S_FAIL: begin
          ERR_MASK <= ERR_MASK | CFG_MASK;
          CFG_MASK <= '0;
          state <= S_NEXT;
        end
        S_NEXT: begin
          rem <= rem & (rem - NADC'(1));
`ifdef ADC_CFG_RETRY_EN
          retry <= '0;
`endif
          state <= S_SCAN;
        end
        S_FINISH: begin
          BUSY <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_cfg_sequencer.sv
// tb_adc_cfg_sequencer: randomized self-checking bench with an abstract job-level model of the sequencer
module tb_adc_cfg_sequencer;
  localparam int NADC = 12, PDLY = 20, TMO = 50, MR = 2, DLY = 10;
`ifdef ADC_CFG_RETRY_EN
  localparam int TRIES = MR + 1;
`else
  localparam int TRIES = 1;
`endif
  logic CLK = 0, RST = 1, PWRUP_EN = 0, JTAG_REQ = 0, CSP_REQ = 0, CFG_DONE = 0;
  logic [NADC-1:0] JTAG_MASK = '0, CSP_MASK = '0, stuck = '0;
  logic CFG_INIT, BUSY, JOB_DONE;
  logic [NADC-1:0] CFG_MASK, ERR_MASK;
  logic [1:0] JOB_SRC;
  int n_cmp = 0, n_bad = 0, cyc = 0, dcnt = 0;
  logic [NADC-1:0] init_q[$], exp_q[$], jd_err[$], exp_err[$];
  logic [1:0] jd_src[$], exp_src[$];
  int init_cyc[$], jd_cyc[$];

  adc_cfg_sequencer #(.NADC(NADC), .PWRUP_DLY(PDLY), .DONE_TMO(TMO), .MAX_RETRY(MR)) dut (
    .CLK(CLK), .RST(RST), .PWRUP_EN(PWRUP_EN), .JTAG_REQ(JTAG_REQ), .JTAG_MASK(JTAG_MASK),
    .CSP_REQ(CSP_REQ), .CSP_MASK(CSP_MASK), .CFG_DONE(CFG_DONE), .CFG_INIT(CFG_INIT),
    .CFG_MASK(CFG_MASK), .BUSY(BUSY), .JOB_DONE(JOB_DONE), .JOB_SRC(JOB_SRC), .ERR_MASK(ERR_MASK)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= RST ? 0 : cyc + 1;

  always @(negedge CLK) begin
    if (CFG_INIT) begin init_q.push_back(CFG_MASK); init_cyc.push_back(cyc); end
    if (JOB_DONE) begin jd_cyc.push_back(cyc); jd_err.push_back(ERR_MASK); jd_src.push_back(JOB_SRC); end
  end

  // adc_config stand-in: DONE rises DLY cycles after INIT unless the selected ADC is stuck
  always @(negedge CLK) begin
    if (RST || CFG_INIT) begin
      CFG_DONE = 1'b0;
      dcnt = RST ? 0 : DLY;
    end else if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0 && (CFG_MASK & ~stuck) != '0) CFG_DONE = 1'b1;
    end
  end

  task automatic clear_logs();
    init_q.delete(); exp_q.delete(); jd_err.delete(); exp_err.delete();
    jd_src.delete(); exp_src.delete(); init_cyc.delete(); jd_cyc.delete();
  endtask

  task automatic add_job(input logic [NADC-1:0] m, input logic [1:0] s);
    logic [NADC-1:0] one;
    one = 1;
    for (int b = 0; b < NADC; b++)
      if (m[b]) for (int r = 0; r < (stuck[b] ? TRIES : 1); r++) exp_q.push_back(one << b);
    exp_err.push_back(m & stuck);
    exp_src.push_back(s);
  endtask

  task automatic wait_done(input int n, input int budget);
    int k;
    k = 0;
    while ((jd_cyc.size() < n || BUSY) && k < budget) begin @(negedge CLK); k++; end
  endtask

  task automatic request(input bit j, input bit c, input logic [NADC-1:0] jm, input logic [NADC-1:0] cm, output int n);
    @(posedge CLK); #1;
    JTAG_MASK = jm; CSP_MASK = cm; JTAG_REQ = j; CSP_REQ = c; n = cyc;
    @(posedge CLK); #1;
    JTAG_REQ = 0; CSP_REQ = 0;
  endtask

  task automatic do_reset(input bit pen);
    @(posedge CLK); #1;
    RST = 1; PWRUP_EN = pen; JTAG_REQ = 0; CSP_REQ = 0;
    repeat (3) @(posedge CLK);
    #1 RST = 0;
    clear_logs();
  endtask

  task automatic test_reset();
    do_reset(0);
    @(negedge CLK);
    n_cmp++; if (CFG_INIT !== 1'b0) begin n_bad++; $display("FAIL reset_init: got %b want 0", CFG_INIT); end
    n_cmp++; if (CFG_MASK !== '0) begin n_bad++; $display("FAIL reset_mask: got %h want 000", CFG_MASK); end
    n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    n_cmp++; if (JOB_DONE !== 1'b0) begin n_bad++; $display("FAIL reset_jobdone: got %b want 0", JOB_DONE); end
    n_cmp++; if (JOB_SRC !== 2'd0) begin n_bad++; $display("FAIL reset_src: got %0d want 0", JOB_SRC); end
    n_cmp++; if (ERR_MASK !== '0) begin n_bad++; $display("FAIL reset_err: got %h want 000", ERR_MASK); end
  endtask

  task automatic test_basic();
    int n;
    clear_logs(); stuck = '0;
    request(1, 0, 12'h005, '0, n);
    wait_done(1, 500);
    add_job(12'h005, 2'd1);
    n_cmp++; if (init_q.size() != exp_q.size()) begin n_bad++; $display("FAIL basic_ninit: got %0d want %0d", init_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < init_q.size()) begin
      n_cmp++; if (init_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL basic_mask%0d: got %h want %h", i, init_q[i], exp_q[i]); end
    end
    n_cmp++; if (jd_cyc.size() != 1) begin n_bad++; $display("FAIL basic_njob: got %0d want 1", jd_cyc.size()); end
    n_cmp++; if ((init_cyc.size() > 0 ? init_cyc[0] - n : -1) != 4) begin n_bad++; $display("FAIL basic_latency: got %0d want 4", init_cyc.size() > 0 ? init_cyc[0] - n : -1); end
    n_cmp++; if ((init_cyc.size() > 1 ? init_cyc[1] - init_cyc[0] : -1) != DLY + 3) begin n_bad++; $display("FAIL basic_slot: got %0d want %0d", init_cyc.size() > 1 ? init_cyc[1] - init_cyc[0] : -1, DLY + 3); end
    if (jd_src.size() > 0) begin
      n_cmp++; if (jd_src[0] !== 2'd1) begin n_bad++; $display("FAIL basic_src: got %0d want 1", jd_src[0]); end
      n_cmp++; if (jd_err[0] !== '0) begin n_bad++; $display("FAIL basic_err: got %h want 000", jd_err[0]); end
    end
  endtask

  task automatic test_pwrup();
    stuck = '0;
    do_reset(1);
    wait_done(1, 400);
    PWRUP_EN = 0;
    add_job(12'hfff, 2'd0);
    n_cmp++; if (jd_cyc.size() != 1) begin n_bad++; $display("FAIL pwrup_njob: got %0d want 1", jd_cyc.size()); end
    n_cmp++; if ((init_cyc.size() > 0 ? init_cyc[0] : -1) != PDLY + 4) begin n_bad++; $display("FAIL pwrup_first: got %0d want %0d", init_cyc.size() > 0 ? init_cyc[0] : -1, PDLY + 4); end
    n_cmp++; if (init_q.size() != exp_q.size()) begin n_bad++; $display("FAIL pwrup_ninit: got %0d want %0d", init_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < init_q.size()) begin
      n_cmp++; if (init_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL pwrup_mask%0d: got %h want %h", i, init_q[i], exp_q[i]); end
    end
    if (jd_src.size() > 0) begin
      n_cmp++; if (jd_src[0] !== 2'd0 || jd_err[0] !== '0) begin n_bad++; $display("FAIL pwrup_job: got src %0d err %h want src 0 err 000", jd_src[0], jd_err[0]); end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    clear_logs(); stuck = '0;
    request(1, 1, 12'h001, 12'h800, n);
    wait_done(2, 800);
    add_job(12'h001, 2'd1);
    add_job(12'h800, 2'd2);
    n_cmp++; if (init_q.size() != exp_q.size()) begin n_bad++; $display("FAIL b2b_ninit: got %0d want %0d", init_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < init_q.size()) begin
      n_cmp++; if (init_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL b2b_mask%0d: got %h want %h", i, init_q[i], exp_q[i]); end
    end
    n_cmp++; if (jd_cyc.size() != 2) begin n_bad++; $display("FAIL b2b_njob: got %0d want 2", jd_cyc.size()); end
    foreach (exp_src[i]) if (i < jd_src.size()) begin
      n_cmp++; if (jd_src[i] !== exp_src[i]) begin n_bad++; $display("FAIL b2b_src%0d: got %0d want %0d", i, jd_src[i], exp_src[i]); end
    end
    if (jd_cyc.size() > 0 && init_cyc.size() > 1) begin
      n_cmp++; if (jd_cyc[0] >= init_cyc[1]) begin n_bad++; $display("FAIL b2b_order: got done %0d init2 %0d want done first", jd_cyc[0], init_cyc[1]); end
    end
  endtask

  task automatic test_timeout();
    int n;
    clear_logs(); stuck = 12'h008;
    request(1, 0, 12'h018, '0, n);
    wait_done(1, 2000);
    add_job(12'h018, 2'd1);
    n_cmp++; if (init_q.size() != exp_q.size()) begin n_bad++; $display("FAIL tmo_ninit: got %0d want %0d", init_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < init_q.size()) begin
      n_cmp++; if (init_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL tmo_mask%0d: got %h want %h", i, init_q[i], exp_q[i]); end
    end
    n_cmp++; if (jd_err.size() != 1 || jd_err[0] !== 12'h008) begin n_bad++; $display("FAIL tmo_err: got %h want 008", jd_err.size() > 0 ? jd_err[0] : 'x); end
    n_cmp++; if ((init_cyc.size() > TRIES ? init_cyc[TRIES] - init_cyc[0] : -1) != TRIES * (TMO + 3) + 3) begin
      n_bad++; $display("FAIL tmo_slot: got %0d want %0d", init_cyc.size() > TRIES ? init_cyc[TRIES] - init_cyc[0] : -1, TRIES * (TMO + 3) + 3);
    end
    stuck = '0;
  endtask

  task automatic test_empty();
    int n;
    clear_logs(); stuck = '0;
    request(0, 1, '0, '0, n);
    wait_done(1, 200);
    n_cmp++; if (init_q.size() != 0) begin n_bad++; $display("FAIL empty_ninit: got %0d want 0", init_q.size()); end
    n_cmp++; if ((jd_cyc.size() > 0 ? jd_cyc[0] - n : -1) != 4) begin n_bad++; $display("FAIL empty_done: got %0d want 4", jd_cyc.size() > 0 ? jd_cyc[0] - n : -1); end
    n_cmp++; if (jd_src.size() != 1 || jd_src[0] !== 2'd2) begin n_bad++; $display("FAIL empty_src: got %0d want 2", jd_src.size() > 0 ? jd_src[0] : 2'bx); end
  endtask

  task automatic test_finish_req();
    int n, k;
    clear_logs(); stuck = '0;
    request(1, 0, 12'h002, '0, n);
    k = 0;
    while (!JOB_DONE && k < 500) begin @(negedge CLK); k++; end
    CSP_MASK = 12'h040; CSP_REQ = 1;
    @(negedge CLK);
    CSP_REQ = 0;
    wait_done(2, 500);
    add_job(12'h002, 2'd1);
    add_job(12'h040, 2'd2);
    n_cmp++; if (jd_cyc.size() != 2) begin n_bad++; $display("FAIL fin_njob: got %0d want 2", jd_cyc.size()); end
    n_cmp++; if (init_q.size() != exp_q.size()) begin n_bad++; $display("FAIL fin_ninit: got %0d want %0d", init_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < init_q.size()) begin
      n_cmp++; if (init_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL fin_mask%0d: got %h want %h", i, init_q[i], exp_q[i]); end
    end
    foreach (exp_src[i]) if (i < jd_src.size()) begin
      n_cmp++; if (jd_src[i] !== exp_src[i]) begin n_bad++; $display("FAIL fin_src%0d: got %0d want %0d", i, jd_src[i], exp_src[i]); end
    end
  endtask

  task automatic test_random();
    int n, which;
    logic [NADC-1:0] jm, cm;
    for (int it = 0; it < 8; it++) begin
      clear_logs();
      stuck = NADC'($urandom & $urandom & $urandom);
      jm = NADC'($urandom);
      cm = NADC'($urandom);
      which = $urandom_range(1, 3);
      request(which[0], which[1], jm, cm, n);
      if (which[0]) add_job(jm, 2'd1);
      if (which[1]) add_job(cm, 2'd2);
      wait_done(exp_src.size(), 8000);
      n_cmp++; if (jd_cyc.size() != exp_src.size()) begin n_bad++; $display("FAIL rnd%0d_njob: got %0d want %0d", it, jd_cyc.size(), exp_src.size()); end
      n_cmp++; if (init_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rnd%0d_ninit: got %0d want %0d", it, init_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < init_q.size()) begin
        n_cmp++; if (init_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rnd%0d_mask%0d: got %h want %h", it, i, init_q[i], exp_q[i]); end
      end
      foreach (exp_src[i]) if (i < jd_src.size()) begin
        n_cmp++; if (jd_src[i] !== exp_src[i] || jd_err[i] !== exp_err[i]) begin
          n_bad++; $display("FAIL rnd%0d_job%0d: got src %0d err %h want src %0d err %h", it, i, jd_src[i], jd_err[i], exp_src[i], exp_err[i]);
        end
      end
    end
    stuck = '0;
  endtask

  task automatic test_reset_mid();
    int n, k;
    clear_logs(); stuck = '1;
    request(0, 1, '0, 12'h020, n);
    k = 0;
    while (init_q.size() == 0 && k < 50) begin @(negedge CLK); k++; end
    repeat (5) @(posedge CLK);
    #1;
    n_cmp++; if (CFG_MASK !== 12'h020 || BUSY !== 1'b1) begin n_bad++; $display("FAIL mid_pre: got mask %h busy %b want 020 1", CFG_MASK, BUSY); end
    RST = 1;
    @(posedge CLK); #1;
    n_cmp++; if (CFG_INIT !== 1'b0 || CFG_MASK !== '0) begin n_bad++; $display("FAIL mid_cfg: got init %b mask %h want 0 000", CFG_INIT, CFG_MASK); end
    n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b want 0", BUSY); end
    n_cmp++; if (JOB_SRC !== 2'd0) begin n_bad++; $display("FAIL mid_src: got %0d want 0", JOB_SRC); end
    repeat (2) @(posedge CLK);
    #1 RST = 0;
    stuck = '0;
    repeat (30) @(posedge CLK);
    #1;
    n_cmp++; if (jd_cyc.size() != 0) begin n_bad++; $display("FAIL mid_nodone: got %0d want 0", jd_cyc.size()); end
    n_cmp++; if (init_q.size() != 1) begin n_bad++; $display("FAIL mid_noinit: got %0d want 1", init_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pwrup();
    test_back_to_back();
    test_timeout();
    test_empty();
    test_finish_req();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/adc_cfg_sequencer.md
# adc_cfg_sequencer

Sequencer and arbiter in front of `adc_config`. It accepts configuration requests from three sources: power-up, JTAG and ChipScope. It serialises them and walks each request's ADC mask one ADC at a time, driving `adc_config`'s INIT and MASK inputs. It supervises `adc_config`'s DONE with a timeout and reports per-ADC failures.

## Interface
Parameters:
- `NADC`, 12: number of ADCs, which is the mask width.
- `PWRUP_DLY`, 1000: CLK cycles from reset release to the automatic power-up request.
- `DONE_TMO`, 4096: CLK cycles allowed per ADC for CFG_DONE to rise.
- `MAX_RETRY`, 2: re-issues per ADC after a timeout. Used only with the retry macro.

Ports:
- `CLK` in, 1: the single clock.
- `RST` in, 1: reset, synchronous, active-high.
- `PWRUP_EN` in, 1: enables the automatic power-up request.
- `JTAG_REQ` in, 1: request, sampled high for one cycle. `JTAG_MASK` in, NADC: that request's ADC mask.
- `CSP_REQ` in, 1: request, sampled high for one cycle. `CSP_MASK` in, NADC: that request's ADC mask.
- `CFG_DONE` in, 1: DONE from `adc_config`.
- `CFG_INIT` out, 1: one-cycle INIT pulse to `adc_config`.
- `CFG_MASK` out, NADC: one-hot select of the ADC being configured. Held for the whole ADC slot.
- `BUSY` out, 1: a job is in progress.
- `JOB_DONE` out, 1: one-cycle pulse at the end of each job.
- `JOB_SRC` out, 2: source of the current or last job. 0 = power-up, 1 = JTAG, 2 = ChipScope.
- `ERR_MASK` out, NADC: ADCs that failed in the current or last job.

## Operation
- **Request latching.** Each source has a pending flag and a stored mask.
  - A request sets the flag and captures its mask. A repeat request while pending overwrites the stored mask.
  - Power-up uses mask all-ones. It is raised once, PWRUP_DLY cycles after reset release, when PWRUP_EN=1.
  - A request arriving while BUSY stays pending.
- **Arbitration.** Fixed priority power-up > JTAG > ChipScope, evaluated only in IDLE. The selected source's pending flag clears on selection.
- **States.**
  - IDLE: when any source is pending → SELECT.
  - SELECT: latch the job mask, JOB_SRC and clear ERR_MASK. Then → SCAN.
  - SCAN: find the lowest set bit of the remaining mask.
    - None found → FINISH.
    - Found → START with CFG_MASK set to that bit.
  - START: CFG_INIT=1 for one cycle and the timer is loaded. Then → GUARD.
  - GUARD: wait 2 cycles, ignoring CFG_DONE. Then → WAIT.
  - WAIT:
    - CFG_DONE=1 → NEXT.
    - Timer reaches DONE_TMO → FAIL.
  - FAIL: set the ERR_MASK bit for the current ADC. Then → NEXT.
  - NEXT: clear the current bit from the remaining mask and set CFG_MASK=0. Then → SCAN.
  - FINISH: JOB_DONE=1. Then → IDLE.
- **Timer.** A 16-bit up-counter that saturates.
- **Empty mask.** A request with mask 0 produces no CFG_INIT. JOB_DONE still pulses.

## Timing
- **Reset values.** All outputs are 0: CFG_INIT, CFG_MASK, BUSY, JOB_DONE, JOB_SRC, ERR_MASK.
  - Pending flags and the power-up delay counter are also cleared, and the FSM goes to IDLE.
- **Request to INIT.** With the sequencer in IDLE and nothing else pending, a request sampled at cycle n gives:
  - cycle n+1: pending flag set.
  - cycle n+2: SELECT.
  - cycle n+3: SCAN.
  - cycle n+4: CFG_INIT high.
- **BUSY** is high from SELECT through FINISH inclusive.
- **CFG_MASK** is valid from START through the cycle before NEXT.
- **Per-ADC slot length.**
  - CFG_DONE already high after GUARD: minimum 5 cycles (START, 2× GUARD, WAIT, NEXT).
  - Timeout: DONE_TMO + 5 cycles.
- **Simultaneous events.**
  - A request in the same cycle as FINISH is latched and served on the next IDLE.
  - All three sources requesting at once are served in priority order across consecutive jobs.
- **Reset mid-job.** The job is abandoned with no JOB_DONE, and CFG_INIT and CFG_MASK drop in the next cycle.

## Configuration
- **`ADC_CFG_RETRY_EN` defined.** A timeout in WAIT returns to START for the same ADC, with a retry counter per ADC slot.
  - The counter resets on NEXT.
  - FAIL is entered only after MAX_RETRY re-issues also time out.
- **`ADC_CFG_RETRY_EN` undefined.** The first timeout goes directly to FAIL. No retry counter is synthesised.

## Structure
- **Package `adc_cfg_pkg`** holds:
  - the state enum;
  - the source codes (SRC_PWRUP, SRC_JTAG, SRC_CSP);
  - the MASK_ALL constant;
  - the GUARD length constant (2).
- **Sub-module `adc_cfg_req_latch`** holds one source's pending flag and stored mask. It is instantiated three times; the power-up instance's mask input is tied to MASK_ALL.
- **Top level** contains the FSM, lowest-set-bit scan, timer and ERR_MASK register.

## Test plan
- JTAG_REQ with mask 12'h005, CFG_DONE modelled high 10 cycles after each INIT → two INIT pulses with CFG_MASK 12'h001 then 12'h004; JOB_DONE pulses; ERR_MASK=0; JOB_SRC=1.
- PWRUP_EN=1, PWRUP_DLY=20 after reset → first INIT at cycle 24 after reset release; 12 INIT pulses in ascending order.
- JTAG_REQ and CSP_REQ in the same cycle, masks 12'h001 and 12'h800 → JTAG job completes first, then ChipScope job; two JOB_DONE pulses.
- CFG_DONE stuck low on ADC 3, mask 12'h018, DONE_TMO=50 → ERR_MASK=12'h008 and ADC 4 still configured.
  - With `ADC_CFG_RETRY_EN` and MAX_RETRY=2: 3 INIT pulses for ADC 3.
- Mask 0 → no INIT; JOB_DONE at cycle n+4.
- RST asserted during WAIT → next cycle CFG_INIT=0, CFG_MASK=0, BUSY=0; no JOB_DONE.
